// File: rtl/multicycle_alu_exec_if.sv
// Handshake/operand bundle between the EX-stage operand muxes and the multicycle ALU.
// The master drives the request; the slave (the ALU) returns registered results.
interface multicycle_alu_exec_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       aluOp;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             divByZero;
  logic             busy;
  logic             done;

  modport master (
    output start, aluOp, opA, opB,
    input  result, zero, divByZero, busy, done
  );

  modport slave (
    input  start, aluOp, opA, opB,
    output result, zero, divByZero, busy, done
  );
endinterface

// File: rtl/multicycle_alu_exec.sv
// EX-stage execution unit: single-cycle logic/add/sub ops plus iterative shift-add MUL
// and restoring DIV, with a registered result and a start/done/busy handshake.
module multicycle_alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_alu_exec_if.slave  aluIf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_XOR = 4'b1001;

  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONE  = {WIDTH{1'b1}};
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } stateT;

  stateT            stateR, stateN;
  logic [CW-1:0]    cntR, cntN;
  // accR: product accumulator (MUL) or partial remainder (DIV)
  // aR:   multiplicand shifting left (MUL) or dividend/quotient shift register (DIV)
  // bR:   multiplier shifting right (MUL) or divisor (DIV)
  logic [WIDTH-1:0] accR, accN;
  logic [WIDTH-1:0] aR, aN;
  logic [WIDTH-1:0] bR, bN;
  logic [WIDTH-1:0] resultR, resultN;
  logic             zeroR, zeroN;
  logic             divByZeroR, divByZeroN;
  logic             busyR, busyN;
  logic             doneR, doneN;

  logic [WIDTH-1:0] aluResultS;
  logic [WIDTH-1:0] mulAccS;
  logic [WIDTH:0]   remShiftS;
  logic [WIDTH:0]   trialS;
  logic             quotBitS;
  logic [WIDTH-1:0] remNextS;
  logic [WIDTH-1:0] quotNextS;

  // One shift-add multiply step and one restoring-divide step, evaluated every cycle.
  assign mulAccS   = accR + (bR[0] ? aR : ALL_ZERO);
  assign remShiftS = {accR, aR[WIDTH-1]};
  assign trialS    = remShiftS - {1'b0, bR};
  assign quotBitS  = ~trialS[WIDTH];
  assign remNextS  = quotBitS ? trialS[WIDTH-1:0] : remShiftS[WIDTH-1:0];
  assign quotNextS = {aR[WIDTH-2:0], quotBitS};

  // Single-cycle operations straight from the request operands.
  always_comb begin
    aluResultS = ALL_ZERO;
    case (aluIf.aluOp)
      OP_ADD:  aluResultS = aluIf.opA + aluIf.opB;
      OP_SUB:  aluResultS = aluIf.opA - aluIf.opB;
      OP_AND:  aluResultS = aluIf.opA & aluIf.opB;
      OP_OR:   aluResultS = aluIf.opA | aluIf.opB;
      OP_NOR:  aluResultS = ~(aluIf.opA | aluIf.opB);
      OP_XOR:  aluResultS = aluIf.opA ^ aluIf.opB;
      OP_SLT:  aluResultS = {{(WIDTH-1){1'b0}}, ($signed(aluIf.opA) < $signed(aluIf.opB))};
      default: aluResultS = ALL_ZERO;
    endcase
  end

  // Next-state, datapath and output-register computation.
  always_comb begin
    stateN     = stateR;
    cntN       = cntR;
    accN       = accR;
    aN         = aR;
    bN         = bR;
    resultN    = resultR;
    zeroN      = zeroR;
    divByZeroN = divByZeroR;
    busyN      = busyR;
    doneN      = 1'b0;

    case (stateR)
      IDLE: begin
        if (aluIf.start) begin
          if (aluIf.aluOp == OP_MUL) begin
            stateN = MUL;
            cntN   = CNT_ZERO;
            busyN  = 1'b1;
            accN   = ALL_ZERO;
            aN     = aluIf.opA;
            bN     = aluIf.opB;
          end else if ((aluIf.aluOp == OP_DIV) && (aluIf.opB != ALL_ZERO)) begin
            stateN = DIV;
            cntN   = CNT_ZERO;
            busyN  = 1'b1;
            accN   = ALL_ZERO;
            aN     = aluIf.opA;
            bN     = aluIf.opB;
          end else if (aluIf.aluOp == OP_DIV) begin
            resultN    = ALL_ONE;
            zeroN      = 1'b0;
            divByZeroN = 1'b1;
            doneN      = 1'b1;
          end else begin
            resultN    = aluResultS;
            zeroN      = (aluResultS == ALL_ZERO);
            divByZeroN = 1'b0;
            doneN      = 1'b1;
          end
        end else begin
          stateN = IDLE;
        end
      end

      MUL: begin
        accN = mulAccS;
        aN   = {aR[WIDTH-2:0], 1'b0};
        bN   = {1'b0, bR[WIDTH-1:1]};
        // The final iteration publishes the product so FIN is the done cycle.
        if (cntR == CNT_LAST) begin
          stateN     = FIN;
          resultN    = mulAccS;
          zeroN      = (mulAccS == ALL_ZERO);
          divByZeroN = 1'b0;
          busyN      = 1'b0;
          doneN      = 1'b1;
        end else begin
          cntN = cntR + CNT_ONE;
        end
      end

      DIV: begin
        accN = remNextS;
        aN   = quotNextS;
        if (cntR == CNT_LAST) begin
          stateN     = FIN;
          resultN    = quotNextS;
          zeroN      = (quotNextS == ALL_ZERO);
          divByZeroN = 1'b0;
          busyN      = 1'b0;
          doneN      = 1'b1;
        end else begin
          cntN = cntR + CNT_ONE;
        end
      end

      FIN: begin
        stateN = IDLE;
      end

      default: begin
        stateN = IDLE;
        busyN  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR     <= IDLE;
      cntR       <= CNT_ZERO;
      accR       <= ALL_ZERO;
      aR         <= ALL_ZERO;
      bR         <= ALL_ZERO;
      resultR    <= ALL_ZERO;
      zeroR      <= 1'b0;
      divByZeroR <= 1'b0;
      busyR      <= 1'b0;
      doneR      <= 1'b0;
    end else begin
      stateR     <= stateN;
      cntR       <= cntN;
      accR       <= accN;
      aR         <= aN;
      bR         <= bN;
      resultR    <= resultN;
      zeroR      <= zeroN;
      divByZeroR <= divByZeroN;
      busyR      <= busyN;
      doneR      <= doneN;
    end
  end

  assign aluIf.result    = resultR;
  assign aluIf.zero      = zeroR;
  assign aluIf.divByZero = divByZeroR;
  assign aluIf.busy      = busyR;
  assign aluIf.done      = doneR;

endmodule

// File: tb/tb_multicycle_alu_exec.sv
// Randomized self-checking bench for multicycle_alu_exec against an arithmetic reference model.
module tb_multicycle_alu_exec;

  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  multicycle_alu_exec_if #(.WIDTH(WIDTH)) aluIf ();

  multicycle_alu_exec #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .aluIf (aluIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the operation's meaning.
  function automatic logic [31:0] refResult(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    prod = {32'd0, a} * {32'd0, b};
    case (op)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return prod[31:0];
      4'd4:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      4'd5:    return a & b;
      4'd6:    return a | b;
      4'd7:    return ~(a | b);
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  // Issue one op, optionally pulse an ADD 1,1 start at cycle 10 (must be ignored), check the outcome.
  task automatic doOp(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input bit injectStart);
    logic [31:0] expRes;
    int          expLat;
    int          cycles;
    int          busyCnt;
    bit          overlap;
    expRes = refResult(op, a, b);
    expLat = ((op == 4'd3) || ((op == 4'd4) && (b != 32'd0))) ? 33 : 1;
    aluIf.start = 1'b1;
    aluIf.aluOp = op;
    aluIf.opA   = a;
    aluIf.opB   = b;
    @(negedge clk);
    cycles  = 1;
    busyCnt = 0;
    overlap = 1'b0;
    aluIf.start = 1'b0;
    aluIf.opA   = $urandom;
    aluIf.opB   = $urandom;
    aluIf.aluOp = 4'($urandom_range(0, 15));
    while (!aluIf.done && cycles < 200) begin
      if (aluIf.busy) busyCnt++;
      if (injectStart && cycles == 10) begin
        aluIf.start = 1'b1;
        aluIf.aluOp = 4'd1;
        aluIf.opA   = 32'd1;
        aluIf.opB   = 32'd1;
      end else begin
        aluIf.start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    aluIf.start = 1'b0;
    if (aluIf.done && aluIf.busy) overlap = 1'b1;
    checkVal({tag, "_latency"}, 64'(cycles), 64'(expLat));
    checkVal({tag, "_result"}, 64'(aluIf.result), 64'(expRes));
    checkVal({tag, "_zero"}, 64'(aluIf.zero), 64'(expRes == 32'd0));
    checkVal({tag, "_divByZero"}, 64'(aluIf.divByZero), 64'((op == 4'd4) && (b == 32'd0)));
    checkVal({tag, "_busyCycles"}, 64'(busyCnt), 64'((expLat == 33) ? 32 : 0));
    checkVal({tag, "_doneBusyOverlap"}, 64'(overlap), 64'd0);
    @(negedge clk);
    checkVal({tag, "_donePulse"}, 64'(aluIf.done), 64'd0);
    checkVal({tag, "_resultHeld"}, 64'(aluIf.result), 64'(expRes));
  endtask

  initial begin
    int doneSeen;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    aluIf.start = 1'b0;
    aluIf.aluOp = 4'd0;
    aluIf.opA   = 32'd0;
    aluIf.opB   = 32'd0;
    repeat (3) @(negedge clk);
    checkVal("reset_outputs", {aluIf.result, aluIf.zero, aluIf.divByZero, aluIf.busy, aluIf.done}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    doOp("add_5_7", 4'd1, 32'd5, 32'd7, 1'b0);
    doOp("sub_3_5", 4'd2, 32'd3, 32'd5, 1'b0);
    doOp("sub_9_9", 4'd2, 32'd9, 32'd9, 1'b0);
    doOp("slt_neg", 4'd8, 32'hFFFF_FFFF, 32'd1, 1'b0);
    doOp("mul_6_7", 4'd3, 32'd6, 32'd7, 1'b0);
    doOp("mul_max", 4'd3, 32'hFFFF_FFFF, 32'd2, 1'b0);
    doOp("div_100_7", 4'd4, 32'd100, 32'd7, 1'b0);
    doOp("div_by_0", 4'd4, 32'd5, 32'd0, 1'b0);
    doOp("nop_unmapped", 4'd13, 32'd5, 32'd9, 1'b0);
    doOp("mul_ignore", 4'd3, 32'd3, 32'd4, 1'b1);
    doOp("add_after", 4'd1, 32'd1, 32'd1, 1'b0);

    // Reset in the middle of a divide.
    aluIf.start = 1'b1;
    aluIf.aluOp = 4'd4;
    aluIf.opA   = 32'd1000;
    aluIf.opB   = 32'd3;
    @(negedge clk);
    aluIf.start = 1'b0;
    repeat (14) @(negedge clk);
    checkVal("div_busy_before_reset", 64'(aluIf.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1 checkVal("async_reset_outputs", {aluIf.result, aluIf.zero, aluIf.divByZero, aluIf.busy, aluIf.done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (aluIf.done || aluIf.busy) doneSeen++;
    end
    checkVal("no_done_after_reset", 64'(doneSeen), 64'd0);
    doOp("add_2_2", 4'd1, 32'd2, 32'd2, 1'b0);

    // Random traffic with biased corner operands.
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = a;
        2:       b = 32'($urandom_range(1, 17));
        3:       a = 32'hFFFF_FFFF;
        default: ;
      endcase
      doOp($sformatf("rand%0d_op%0d", i, op), op, a, b, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
